// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu: registered EX-stage ALU with valid/ready handshake and a one-entry result register.
// Define ALU_SEQ_MDU_EN to compile in the iterative multiply/divide unit (MUL/DIV/REM).
module alu_seq_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [5:0]       iALUFun,
    input  logic             iSign,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oZ,
    output logic             oV,
    output logic             oN,
    output logic             oBusy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b011000;
    localparam logic [5:0] OP_OR  = 6'b011110;
    localparam logic [5:0] OP_XOR = 6'b010110;
    localparam logic [5:0] OP_NOR = 6'b010001;
    localparam logic [5:0] OP_A   = 6'b011010;
    localparam logic [5:0] OP_SLL = 6'b100000;
    localparam logic [5:0] OP_SRL = 6'b100001;
    localparam logic [5:0] OP_SRA = 6'b100011;
    localparam logic [5:0] OP_EQ  = 6'b110011;
    localparam logic [5:0] OP_NEQ = 6'b110001;
    localparam logic [5:0] OP_LT  = 6'b110101;
    localparam logic [5:0] OP_LEZ = 6'b111101;
    localparam logic [5:0] OP_GEZ = 6'b111001;
    localparam logic [5:0] OP_GTZ = 6'b111111;
`ifdef ALU_SEQ_MDU_EN
    localparam logic [5:0] OP_MUL = 6'b001000;
    localparam logic [5:0] OP_DIV = 6'b001001;
    localparam logic [5:0] OP_REM = 6'b001011;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   addFull;
    logic [WIDTH:0]   subFull;
    logic [WIDTH-1:0] aluS;
    logic             aluV;
    logic             aluN;
    logic             cond;
    logic             isMdu;
    logic             accept;

    logic [WIDTH-1:0] mduS;
    logic             mduV;
    logic             mduWrite;

    logic             validReg;
    logic [WIDTH-1:0] sReg;
    logic             zReg;
    logic             vReg;
    logic             nReg;

    assign sh      = iA[SHW-1:0];
    assign addFull = {1'b0, iA} + {1'b0, iB};
    assign subFull = {1'b0, iA} - {1'b0, iB};
    assign accept  = iValid && oReady;

    // Single-cycle result path; anything not decoded falls into the illegal-code result.
    always_comb begin
        aluS  = '0;
        aluV  = 1'b0;
        aluN  = 1'b0;
        cond  = 1'b0;
        isMdu = 1'b0;
        case (iALUFun)
            OP_ADD: begin
                aluS = addFull[MSB:0];
                if (iSign) begin
                    aluV = (iA[MSB] == iB[MSB]) && (addFull[MSB] != iA[MSB]);
                    aluN = addFull[MSB] ^ aluV;
                end else begin
                    aluV = addFull[WIDTH];
                end
            end
            OP_SUB: begin
                aluS = subFull[MSB:0];
                if (iSign) begin
                    aluV = (iA[MSB] != iB[MSB]) && (subFull[MSB] != iA[MSB]);
                    aluN = subFull[MSB] ^ aluV;
                end else begin
                    aluV = subFull[WIDTH];
                    aluN = subFull[WIDTH];
                end
            end
            OP_AND: aluS = iA & iB;
            OP_OR:  aluS = iA | iB;
            OP_XOR: aluS = iA ^ iB;
            OP_NOR: aluS = ~(iA | iB);
            OP_A:   aluS = iA;
            OP_SLL: aluS = iB << sh;
            OP_SRL: aluS = iB >> sh;
            OP_SRA: aluS = $signed(iB) >>> sh;
            OP_EQ: begin
                cond = (iA == iB);
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
            OP_NEQ: begin
                cond = (iA != iB);
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
            OP_LT: begin
                cond = iSign ? ($signed(iA) < $signed(iB)) : (iA < iB);
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
            OP_LEZ: begin
                cond = iA[MSB] || (iA == '0);
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
            OP_GEZ: begin
                cond = !iA[MSB];
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
            OP_GTZ: begin
                cond = !iA[MSB] && (iA != '0);
                aluS = {{(WIDTH-1){1'b0}}, cond};
            end
`ifdef ALU_SEQ_MDU_EN
            OP_MUL, OP_DIV, OP_REM: isMdu = 1'b1;
`endif
            default: aluV = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MDU_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

    stateT            state;
    stateT            stateNext;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] origA;
    logic [1:0]       mduOp;
    logic             signFlag;
    logic             negFlag;
    logic             divZero;
    logic             divOvf;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divFits;
    logic             mduStart;
    logic [2*WIDTH-1:0] prodSigned;

    assign aMag     = (iSign && iA[MSB]) ? -iA : iA;
    assign bMag     = (iSign && iB[MSB]) ? -iB : iB;
    assign mduStart = accept && isMdu;
    assign mduWrite = (state == FIX);
    assign oBusy    = (state != IDLE);
    assign oReady   = iRstN && (state == IDLE) && (!validReg || iReady);

    // accHi:accLo is the product for MUL, and remainder:dividend/quotient for DIV/REM.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    assign divShift = {accHi, accLo[MSB]};
    assign divFits  = (divShift >= {1'b0, opnd});
    assign divDiff  = divShift - {1'b0, opnd};

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (mduStart) stateNext = RUN;
            RUN:     if (cnt == '0) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            opnd     <= '0;
            origA    <= '0;
            mduOp    <= '0;
            signFlag <= 1'b0;
            negFlag  <= 1'b0;
            divZero  <= 1'b0;
            divOvf   <= 1'b0;
        end else if (mduStart) begin
            cnt      <= SHW'(WIDTH - 1);
            accHi    <= '0;
            accLo    <= (iALUFun == OP_MUL) ? bMag : aMag;
            opnd     <= (iALUFun == OP_MUL) ? aMag : bMag;
            origA    <= iA;
            mduOp    <= iALUFun[1:0];
            signFlag <= iSign;
            // Remainder follows the dividend's sign; product and quotient follow the sign XOR.
            negFlag  <= iSign && ((iALUFun == OP_REM) ? iA[MSB] : (iA[MSB] ^ iB[MSB]));
            divZero  <= (iB == '0);
            divOvf   <= iSign && (iA == MIN_VAL) && (iB == '1);
        end else if (state == RUN) begin
            cnt <= cnt - SHW'(1);
            if (mduOp == 2'b00) begin
                accHi <= mulSum[WIDTH:1];
                accLo <= {mulSum[0], accLo[MSB:1]};
            end else if (divFits) begin
                accHi <= divDiff[MSB:0];
                accLo <= {accLo[MSB-1:0], 1'b1};
            end else begin
                accHi <= divShift[MSB:0];
                accLo <= {accLo[MSB-1:0], 1'b0};
            end
        end
    end

    always_comb begin
        prodSigned = negFlag ? -{accHi, accLo} : {accHi, accLo};
        mduS       = '0;
        mduV       = 1'b0;
        case (mduOp)
            2'b00: begin
                mduS = prodSigned[MSB:0];
                mduV = signFlag ? (prodSigned[2*WIDTH-1:WIDTH] != {WIDTH{prodSigned[MSB]}})
                                : (accHi != '0);
            end
            2'b01: begin
                if (divZero) begin
                    mduS = '1;
                    mduV = 1'b1;
                end else begin
                    mduS = negFlag ? -accLo : accLo;
                    mduV = divOvf;
                end
            end
            default: begin
                if (divZero) begin
                    mduS = origA;
                    mduV = 1'b1;
                end else if (divOvf) begin
                    mduS = '0;
                    mduV = 1'b1;
                end else begin
                    mduS = negFlag ? -accHi : accHi;
                end
            end
        endcase
    end
`else
    assign oBusy    = 1'b0;
    assign oReady   = iRstN && (!validReg || iReady);
    assign mduWrite = 1'b0;
    assign mduS     = '0;
    assign mduV     = 1'b0;
`endif

    // Output register: an MDU write never collides with an accept, since accept requires IDLE.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            validReg <= 1'b0;
            sReg     <= '0;
            zReg     <= 1'b1;
            vReg     <= 1'b0;
            nReg     <= 1'b0;
        end else if (mduWrite) begin
            validReg <= 1'b1;
            sReg     <= mduS;
            zReg     <= (mduS == '0);
            vReg     <= mduV;
            nReg     <= 1'b0;
        end else if (accept && !isMdu) begin
            validReg <= 1'b1;
            sReg     <= aluS;
            zReg     <= (aluS == '0);
            vReg     <= aluV;
            nReg     <= aluN;
        end else if (validReg && iReady) begin
            validReg <= 1'b0;
        end
    end

    assign oValid = validReg;
    assign oS     = sReg;
    assign oZ     = zReg;
    assign oV     = vReg;
    assign oN     = nReg;

endmodule

// File: tb/tb_alu_seq_mdu.sv
// Directed self-checking bench for alu_seq_mdu (WIDTH=32); MDU sequences compile when ALU_SEQ_MDU_EN is defined.
module tb_alu_seq_mdu;
    localparam int WIDTH = 32;

    logic             iClk = 1'b0;
    logic             iRstN;
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [5:0]       iALUFun;
    logic             iSign;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oS;
    logic             oZ;
    logic             oV;
    logic             oN;
    logic             oBusy;

    int passed = 0;
    int total  = 0;

    alu_seq_mdu #(.WIDTH(WIDTH)) dut (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .iALUFun(iALUFun), .iSign(iSign),
        .oValid(oValid), .iReady(iReady), .oS(oS), .oZ(oZ), .oV(oV), .oN(oN),
        .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        string       name;
        logic [5:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } vecT;

    vecT vecs[$];

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic drive(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic sign);
        iALUFun = fun;
        iA      = a;
        iB      = b;
        iSign   = sign;
        iValid  = 1'b1;
    endtask

`ifdef ALU_SEQ_MDU_EN
    task automatic runMdu(input string name, input logic [5:0] fun, input logic [31:0] a,
                          input logic [31:0] b, input logic sign,
                          input logic [31:0] expS, input logic expV);
        int lat;
        drive(fun, a, b, sign);
        iReady = 1'b1;
        tick();
        iValid = 1'b0;
        check({name, " busy"}, 32'(oBusy), 32'd1);
        check({name, " ready"}, 32'(oReady), 32'd0);
        lat = 0;
        while (!oValid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(WIDTH + 1));
        check({name, " S"}, oS, expS);
        check({name, " V"}, 32'(oV), 32'(expV));
        check({name, " busy after"}, 32'(oBusy), 32'd0);
        $display("mdu %s: lat=%0d oS=0x%08h V=%0d", name, lat, oS, oV);
    endtask
`endif

    initial begin
        bit sawValid;

        vecs.push_back('{"add_sovf",  6'b000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_ubrw",  6'b000001, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"add_ucar",  6'b000000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"add_snneg", 6'b000000, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{"sub_szero", 6'b000001, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_sneg",  6'b000001, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"and",       6'b011000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or",        6'b011110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"xor",       6'b010110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"nor",       6'b010001, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h000F000F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"passa",     6'b011010, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sll",       6'b100000, 32'h00000004, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"srl",       6'b100001, 32'h00000004, 32'h80000000, 1'b0, 32'h08000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sra",       6'b100011, 32'h00000004, 32'h80000000, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sra31",     6'b100011, 32'h0000003F, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"eq",        6'b110011, 32'h00000005, 32'h00000005, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"neq",       6'b110001, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"lt_s",      6'b110101, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lt_u",      6'b110101, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"lez0",      6'b111101, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"gez_neg",   6'b111001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"gtz1",      6'b111111, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"gtz_min",   6'b111111, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"illegal",   6'b000111, 32'h12345678, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
`ifndef ALU_SEQ_MDU_EN
        vecs.push_back('{"mul_off",   6'b001000, 32'h00000007, 32'h00000006, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"div_off",   6'b001001, 32'h00000007, 32'h00000002, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"rem_off",   6'b001011, 32'h00000007, 32'h00000002, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
`endif

        iRstN   = 1'b0;
        iValid  = 1'b0;
        iReady  = 1'b0;
        iA      = '0;
        iB      = '0;
        iALUFun = '0;
        iSign   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst valid", 32'(oValid), 32'd0);
        check("rst S", oS, 32'd0);
        check("rst Z", 32'(oZ), 32'd1);
        check("rst V", 32'(oV), 32'd0);
        check("rst N", 32'(oN), 32'd0);
        check("rst ready", 32'(oReady), 32'd0);
        check("rst busy", 32'(oBusy), 32'd0);
        iRstN = 1'b1;
        tick();
        check("post-rst ready", 32'(oReady), 32'd1);
        check("post-rst valid", 32'(oValid), 32'd0);
        $display("reset: oValid=%0d oReady=%0d", oValid, oReady);

        // Back-to-back single-cycle vectors
        iReady = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].sign);
            check({vecs[i].name, " ready"}, 32'(oReady), 32'd1);
            tick();
            check({vecs[i].name, " valid"}, 32'(oValid), 32'd1);
            check({vecs[i].name, " S"}, oS, vecs[i].s);
            check({vecs[i].name, " Z"}, 32'(oZ), 32'(vecs[i].z));
            check({vecs[i].name, " V"}, 32'(oV), 32'(vecs[i].v));
            check({vecs[i].name, " N"}, 32'(oN), 32'(vecs[i].n));
            $display("vec %0d %s: oS=0x%08h Z=%0d V=%0d N=%0d", i, vecs[i].name, oS, oZ, oV, oN);
        end

        // Backpressure: hold an SRA result while an ADD waits
        drive(6'b100011, 32'd4, 32'h80000000, 1'b0);
        tick();
        check("bp first", oS, 32'hF8000000);
        iReady = 1'b0;
        drive(6'b000000, 32'd1, 32'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp ready", 32'(oReady), 32'd0);
            tick();
            check("bp hold S", oS, 32'hF8000000);
            check("bp hold valid", 32'(oValid), 32'd1);
            $display("bp cycle %0d: oS=0x%08h oReady=%0d", c, oS, oReady);
        end
        iReady = 1'b1;
        #1;
        check("bp release ready", 32'(oReady), 32'd1);
        tick();
        check("bp queued S", oS, 32'd3);
        check("bp queued valid", 32'(oValid), 32'd1);
        iValid = 1'b0;
        tick();
        check("consume valid", 32'(oValid), 32'd0);
        $display("bp release: queued ADD oS=0x%08h consumed oValid=%0d", oS, oValid);

`ifdef ALU_SEQ_MDU_EN
        runMdu("mul_neg",  6'b001000, 32'hFFFFFFF9, 32'd6,        1'b1, 32'hFFFFFFD6, 1'b0);
        runMdu("div_neg",  6'b001001, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 1'b0);
        runMdu("rem_neg",  6'b001011, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 1'b0);
        runMdu("mul_uovf", 6'b001000, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1);
        runMdu("div_0",    6'b001001, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b1);
        runMdu("rem_0",    6'b001011, 32'd5,        32'd0,        1'b0, 32'd5,        1'b1);
        runMdu("div_ovf",  6'b001001, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1);
        runMdu("rem_ovf",  6'b001011, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
        runMdu("div_u",    6'b001001, 32'd100,      32'd7,        1'b0, 32'd14,       1'b0);

        // Abort an iteration with reset
        drive(6'b001000, 32'd3, 32'd3, 1'b0);
        tick();
        iValid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        iRstN = 1'b0;
        #1;
        check("abort busy", 32'(oBusy), 32'd0);
        check("abort valid", 32'(oValid), 32'd0);
        tick();
        iRstN = 1'b1;
        sawValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (oValid) sawValid = 1'b1;
        end
        check("abort no result", 32'(sawValid), 32'd0);
        check("abort ready", 32'(oReady), 32'd1);
        $display("abort: oBusy=%0d oValid=%0d", oBusy, oValid);
`else
        check("no mdu busy", 32'(oBusy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
